matrix_scan_controller: RTL and testbench

//  Sequencer for a key/switch matrix built from a 3-to-8 active-low row decoder and column read-back.

---
 rtl/matrix_scan_pkg.sv | 22 ++
 rtl/matrix_event_fifo.sv | 52 +++++
 rtl/matrix_scan_controller.sv | 190 +++++++++++++++++++
 tb/tb_matrix_scan_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_pkg.sv
// Shared types for the key-matrix scanner: FSM states, event layout, row count.
// No logic; imported by the scanner and its event FIFO.
package matrix_scan_pkg;

  localparam int ROW_COUNT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    SAMPLE  = 3'd2,
    COMPARE = 3'd3,
    NEXT    = 3'd4
  } state_t;

  typedef struct packed {
    logic       press;
    logic       rsvd;
    logic [2:0] row;
    logic [2:0] col;
  } event_t;

endpackage

// File: rtl/matrix_event_fifo.sv
// Small event FIFO: push when not full, head visible combinationally; zero-latency read.
// Latency: pushed entry is visible at the head the cycle after push; DEPTH must be a power of two.
// Backpressure: full_o blocks the producer; pop_i is ignored while empty.
module matrix_event_fifo
  import matrix_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  event_t push_dat_i,
  output logic   full_o,
  input  logic   pop_i,
  output logic   empty_o,
  output event_t head_dat_o
);

  localparam int AW = $clog2(DEPTH);

  event_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_fire, pop_fire;

  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign push_fire  = push_i && !full_o;
  assign pop_fire   = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_fire) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_fire) rd_q <= rd_q + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/matrix_scan_controller.sv
// Key-matrix scanner with per-row debounce and a press/release event stream (MATRIX_SCAN_FIFO_EN adds a 4-deep event FIFO).
// Latency: row period SETTLE_CYCLES+3 clocks with no events; one event per clock from COMPARE.
// Backpressure: COMPARE stalls while the output register (or FIFO) cannot take another event.
module matrix_scan_controller
  import matrix_scan_pkg::*;
#(
  parameter int COLS           = 5,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scan_en,
  output logic [2:0]      row_sel,
  output logic            row_en,
  input  logic [COLS-1:0] col_n,
  output logic            event_valid,
  input  logic            event_ready,
  output logic [7:0]      event_code,
  output logic            key_any
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [COLS-1:0] committed_q [ROW_COUNT];
  logic [COLS-1:0] cand_q      [ROW_COUNT];
  logic [3:0]      cnt_q       [ROW_COUNT];

  logic [COLS-1:0] samp, diff, low_mask;
  logic [COLS-1:0] cand_row_d;
  logic [3:0]      cnt_row_d;
  logic [2:0]      sel_col;
  logic            can_load, load;
  event_t          new_evt;

  assign samp = ~col_n;
  assign row_sel = row_q;

  // Debounce: count consecutive identical samples, restart on any change.
  always_comb begin
    cand_row_d = cand_q[row_q];
    cnt_row_d  = cnt_q[row_q];
    if (samp == cand_q[row_q]) begin
      if (cnt_q[row_q] != 4'(DEBOUNCE_SCANS)) cnt_row_d = cnt_q[row_q] + 4'd1;
    end else begin
      cand_row_d = samp;
      cnt_row_d  = 4'd1;
    end
  end

  assign diff     = (cnt_q[row_q] == 4'(DEBOUNCE_SCANS)) ? (committed_q[row_q] ^ cand_q[row_q]) : '0;
  assign low_mask = diff & (~diff + 1'b1);

  always_comb begin
    sel_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (diff[i]) sel_col = 3'(i);
    end
  end

  always_comb begin
    new_evt       = '0;
    new_evt.press = |(cand_q[row_q] & low_mask);
    new_evt.row   = row_q;
    new_evt.col   = sel_col;
  end

  assign load = (state_q == COMPARE) && (|diff) && can_load;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    row_en   = 1'b0;
    case (state_q)
      IDLE: begin
        row_d    = '0;
        settle_d = '0;
        if (scan_en) state_d = DRIVE;
      end
      DRIVE: begin
        row_en = 1'b1;
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SAMPLE: begin
        row_en  = 1'b1;
        state_d = COMPARE;
      end
      COMPARE: begin
        if (diff == '0) state_d = NEXT;
      end
      NEXT: begin
        if (scan_en) begin
          row_d   = row_q + 3'd1;
          state_d = DRIVE;
        end else begin
          row_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      settle_q <= '0;
      for (int r = 0; r < ROW_COUNT; r++) begin
        committed_q[r] <= '0;
        cand_q[r]      <= '0;
        cnt_q[r]       <= '0;
      end
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      if (state_q == SAMPLE) begin
        cand_q[row_q] <= cand_row_d;
        cnt_q[row_q]  <= cnt_row_d;
      end
      if (load) committed_q[row_q] <= committed_q[row_q] ^ low_mask;
    end
  end

  always_comb begin
    key_any = 1'b0;
    for (int r = 0; r < ROW_COUNT; r++) key_any = key_any | (|committed_q[r]);
  end

`ifdef MATRIX_SCAN_FIFO_EN
  logic   fifo_full, fifo_empty;
  event_t fifo_head;

  matrix_event_fifo #(.DEPTH(4)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (load),
    .push_dat_i (new_evt),
    .full_o     (fifo_full),
    .pop_i      (event_ready),
    .empty_o    (fifo_empty),
    .head_dat_o (fifo_head)
  );

  assign can_load    = !fifo_full;
  assign event_valid = !fifo_empty;
  assign event_code  = fifo_head;
`else
  event_t out_q, out_d;
  logic   out_vld_q, out_vld_d;

  // A new event may replace the one being accepted in the same cycle.
  assign can_load = !out_vld_q || event_ready;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (load) begin
      out_d     = new_evt;
      out_vld_d = 1'b1;
    end else if (event_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign event_valid = out_vld_q;
  assign event_code  = out_q;
`endif

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: a key-matrix model on col_n and a scoreboard of expected event codes.
// Works with and without MATRIX_SCAN_FIFO_EN.
module tb_matrix_scan_controller;

  localparam int COLS  = 5;
  localparam int FRAME = 8 * 19;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            scan_en;
  logic [2:0]      row_sel;
  logic            row_en;
  logic [COLS-1:0] col_n;
  logic            event_valid;
  logic            event_ready;
  logic [7:0]      event_code;
  logic            key_any;

  logic [COLS-1:0] key_map [8];
  logic            bounce_en = 1'b0;
  logic            bounce_val = 1'b0;
  logic            prev_en = 1'b0;
  logic [COLS-1:0] bounce_bits;

  int        n_tests = 0;
  int        n_fail  = 0;
  int        n_evt   = 0;
  int        cyc     = 0;
  bit        log_en  = 1'b0;
  logic [7:0] sb [$];
  int        acc_cyc [$];

  matrix_scan_controller #(.COLS(COLS), .SETTLE_CYCLES(16), .DEBOUNCE_SCANS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .row_sel     (row_sel),
    .row_en      (row_en),
    .col_n       (col_n),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_code  (event_code),
    .key_any     (key_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bounce_bits = (bounce_en && bounce_val && row_sel == 3'd5) ? 5'b00001 : 5'b00000;
  assign col_n = row_en ? ~(key_map[row_sel] | bounce_bits) : {COLS{1'b1}};

  // Bouncing key flips state once per visit to row 5.
  always @(negedge clk) begin
    prev_en <= row_en;
    if (row_en && !prev_en && row_sel == 3'd5) bounce_val <= ~bounce_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: each handshake pops and checks the scoreboard.
  always @(negedge clk) begin
    if (rst_n && event_valid && event_ready) begin
      n_evt++;
      if (log_en) acc_cyc.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_evt", {24'b0, event_code}, 32'h100);
      else chk("evt_code", {24'b0, event_code}, {24'b0, sb.pop_front()});
    end
  end

  task automatic wait_drain(input string tag, input int max_cyc);
    int k = 0;
    while (sb.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_row_en(input logic lvl, input int max_cyc, input string tag);
    int k = 0;
    while (row_en !== lvl && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cyc) chk(tag, {31'b0, row_en}, {31'b0, lvl});
  endtask

  task automatic wait_row(input logic [2:0] r, input int max_cyc, input string tag);
    int k = 0;
    while (!(row_en === 1'b1 && row_sel === r) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cyc) chk(tag, {29'b0, row_sel}, {29'b0, r});
  endtask

  task automatic high_len(output int hi);
    hi = 0;
    while (row_en === 1'b1 && hi < 40) begin
      @(negedge clk);
      hi++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hi, rise_prev, k;
    bit  stable;
    rst_n = 1'b0;
    scan_en = 1'b0;
    event_ready = 1'b1;
    for (int r = 0; r < 8; r++) key_map[r] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_en", {31'b0, row_en}, 0);
    chk("rst_row_sel", {29'b0, row_sel}, 0);
    chk("rst_valid", {31'b0, event_valid}, 0);
    chk("rst_code", {24'b0, event_code}, 0);
    chk("rst_key_any", {31'b0, key_any}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 scan_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("drive_row_en", {31'b0, row_en}, 1);

    // Async reset mid-DRIVE
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_row_en", {31'b0, row_en}, 0);
    chk("arst_row_sel", {29'b0, row_sel}, 0);
    chk("arst_valid", {31'b0, event_valid}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Row timing and row_sel wrap
    rise_prev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_row_en(1'b1, 60, "row_rise_timeout");
      chk($sformatf("row_sel_%0d", i), {29'b0, row_sel}, i % 8);
      if (i > 0) chk("row_period", cyc - rise_prev, 19);
      rise_prev = cyc;
      high_len(hi);
      chk("row_en_high", hi, 17);
    end

    // Single key press / release
    key_map[2][1] = 1'b1;
    sb.push_back(8'h91);
    wait_drain("drain_press_r2c1", 6 * FRAME);
    chk("key_any_on", {31'b0, key_any}, 1);
    key_map[2][1] = 1'b0;
    sb.push_back(8'h11);
    wait_drain("drain_rel_r2c1", 6 * FRAME);
    chk("key_any_off", {31'b0, key_any}, 0);

    // Bouncing key never commits
    k = n_evt;
    bounce_en = 1'b1;
    repeat (6 * FRAME) @(negedge clk);
    chk("bounce_no_evt", n_evt - k, 0);
    chk("bounce_key_any", {31'b0, key_any}, 0);
    bounce_en = 1'b0;
    repeat (5 * FRAME) @(negedge clk);
    chk("bounce_after", n_evt - k, 0);

    // Three keys in one row, held off by ready=0
    event_ready = 1'b0;
    key_map[3] = 5'b10101;
    sb.push_back(8'h98);
    sb.push_back(8'h9A);
    sb.push_back(8'h9C);
    k = 0;
    while (event_valid !== 1'b1 && k < 6 * FRAME) begin
      @(negedge clk);
      k++;
    end
    chk("multi_valid", {31'b0, event_valid}, 1);
    chk("multi_first", {24'b0, event_code}, 32'h98);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (event_valid !== 1'b1 || event_code !== 8'h98) stable = 1'b0;
    end
    chk("multi_stable", {31'b0, stable}, 1);
    acc_cyc.delete();
    log_en = 1'b1;
    event_ready = 1'b1;
    wait_drain("drain_multi", 200);
    log_en = 1'b0;
    chk("multi_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_1", acc_cyc[1] - acc_cyc[0], 1);
      chk("b2b_2", acc_cyc[2] - acc_cyc[1], 1);
    end
    key_map[3] = '0;
    sb.push_back(8'h18);
    sb.push_back(8'h1A);
    sb.push_back(8'h1C);
    wait_drain("drain_multi_rel", 6 * FRAME);

    // Five events queued behind ready=0: no loss, order kept
    event_ready = 1'b0;
    key_map[0] = 5'b11111;
    for (int c = 0; c < 5; c++) sb.push_back(8'h80 | 8'(c));
    repeat (6 * FRAME) @(negedge clk);
    chk("q5_valid", {31'b0, event_valid}, 1);
    chk("q5_head", {24'b0, event_code}, 32'h80);
    event_ready = 1'b1;
    wait_drain("drain_q5", 6 * FRAME);
    key_map[0] = '0;
    for (int c = 0; c < 5; c++) sb.push_back(8'(c));
    wait_drain("drain_q5_rel", 6 * FRAME);

    // scan_en dropped during DRIVE of row 4
    wait_row(3'd3, 2 * FRAME, "wait_row3");
    wait_row(3'd4, 2 * FRAME, "wait_row4");
    scan_en = 1'b0;
    high_len(hi);
    chk("stop_row4_high", hi, 17);
    k = 0;
    repeat (60) begin
      @(negedge clk);
      if (row_en === 1'b1) k++;
    end
    chk("idle_row_en", k, 0);
    chk("idle_row_sel", {29'b0, row_sel}, 0);
    chk("idle_no_evt", {31'b0, event_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
